tea_round_sequencer: RTL



---
 rtl/tea_round_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tea_round_sequencer.sv
// Control sequencer for the TEA round datapath.
//
// A pass runs IDLE -> LOAD -> ROUND x ROUNDS -> DONE -> IDLE. In ROUND the sequencer
// holds round_req_o high and advances round_idx_o and sum_o on each round_ack_i. The
// sum is preloaded for the selected direction and then accumulated (encrypt) or
// decremented (decrypt) by DELTA, modulo 2^SUM_W. abort_i cancels a pass from LOAD
// or ROUND and takes priority over round_ack_i.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_i      begin a pass (sampled only in IDLE)
//   decrypt_i    direction, latched with start_i: 0 encrypt, 1 decrypt
//   abort_i      synchronous cancel while busy
//   round_ack_i  datapath consumed the current round
//   load_data_o  one-cycle strobe: datapath loads block and key
//   round_req_o  datapath should run round round_idx_o with sum_o
//   round_idx_o  current round number
//   sum_o        key-schedule sum for the current round
//   busy_o       pass in progress (LOAD or ROUND)
//   done_o       one-cycle strobe: pass completed
module tea_round_sequencer #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned SUM_W  = 32,
  parameter logic [SUM_W-1:0] DELTA = SUM_W'(32'h9E3779B9)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             decrypt_i,
  input  logic             abort_i,
  input  logic             round_ack_i,
  output logic             load_data_o,
  output logic             round_req_o,
  output logic [IDX_W-1:0] round_idx_o,
  output logic [SUM_W-1:0] sum_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROUNDS - 1);
  // Decrypt walks the schedule backwards, starting from the final encrypt sum.
  localparam logic [SUM_W-1:0] SumDecInit = SUM_W'(DELTA * SUM_W'(ROUNDS));

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             mode_q, mode_d;
  logic             load_q, req_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = decrypt_i;
          idx_d   = '0;
          sum_d   = decrypt_i ? SumDecInit : DELTA;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = abort_i ? StIdle : StRound;
      end
      StRound: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (round_ack_i) begin
          sum_d = mode_q ? (sum_q - DELTA) : (sum_q + DELTA);
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      load_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      mode_q  <= mode_d;
      load_q  <= (state_d == StLoad);
      req_q   <= (state_d == StRound);
      busy_q  <= (state_d == StLoad) || (state_d == StRound);
      done_q  <= (state_d == StDone);
    end
  end

  assign load_data_o = load_q;
  assign round_req_o = req_q;
  assign round_idx_o = idx_q;
  assign sum_o       = sum_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
